// File: rtl/cu_mem_arbiter_if.sv
// Thread-side and memory-side bus bundle for cu_mem_arbiter.
// slave is the arbiter's view; master is the view of the LSUs and memory around it.
interface cu_mem_arbiter_if #(
  parameter int NUM_THREADS     = 4,
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 8
);
  logic [NUM_THREADS-1:0]                 thr_req_val;
  logic [NUM_THREADS-1:0]                 thr_req_we;
  logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] thr_req_addr;
  logic [NUM_THREADS*DATA_WIDTH-1:0]      thr_req_data;
  logic [NUM_THREADS-1:0]                 thr_req_rdy;
  logic [NUM_THREADS-1:0]                 thr_resp_val;
  logic [NUM_THREADS*DATA_WIDTH-1:0]      thr_resp_data;

  logic [NUM_CHANNELS-1:0]                 mem_req_val;
  logic [NUM_CHANNELS-1:0]                 mem_req_rdy;
  logic [NUM_CHANNELS-1:0]                 mem_req_we;
  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0] mem_req_addr;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      mem_req_data;
  logic [NUM_CHANNELS-1:0]                 mem_resp_val;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      mem_resp_data;

  modport slave (
    input  thr_req_val, thr_req_we, thr_req_addr, thr_req_data,
    output thr_req_rdy, thr_resp_val, thr_resp_data,
    output mem_req_val, mem_req_we, mem_req_addr, mem_req_data,
    input  mem_req_rdy, mem_resp_val, mem_resp_data
  );

  modport master (
    output thr_req_val, thr_req_we, thr_req_addr, thr_req_data,
    input  thr_req_rdy, thr_resp_val, thr_resp_data,
    input  mem_req_val, mem_req_we, mem_req_addr, mem_req_data,
    output mem_req_rdy, mem_resp_val, mem_resp_data
  );
endinterface

// File: rtl/cu_mem_arbiter.sv
// Merges NUM_THREADS LSU channels onto NUM_CHANNELS memory channels (round-robin + in-order tag FIFO).
// Define CU_MEM_ARBITER_PERF_EN to add per-channel saturating stall counters (perf_stall_cnt).
module cu_mem_arbiter #(
  parameter int NUM_THREADS     = 4,
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int DEPTH           = 4
) (
  input  logic clk,
  input  logic reset,
  cu_mem_arbiter_if.slave bus
`ifdef CU_MEM_ARBITER_PERF_EN
  ,
  output logic [NUM_CHANNELS*16-1:0] perf_stall_cnt
`endif
);

  localparam int TPC = NUM_THREADS / NUM_CHANNELS;
  localparam int TW  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int LW  = (TPC > 1) ? $clog2(TPC) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [NUM_CHANNELS-1:0] pop;
  logic [TW-1:0]           head_tag [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [TPC-1:0]             cand_val;
    logic                       cand_we   [TPC];
    logic [DATA_ADDR_WIDTH-1:0] cand_addr [TPC];
    logic [DATA_WIDTH-1:0]      cand_data [TPC];
    logic [LW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]              gnt_local, idx;
    logic [TW-1:0]              gnt_thread;
    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              head_q, tail_q;
    logic [TW-1:0]              tag_q [DEPTH];
    logic                       any_val, full, fire;

    for (genvar k = 0; k < TPC; k++) begin : g_cand
      localparam int T = c + k * NUM_CHANNELS;
      assign cand_val[k]  = bus.thr_req_val[T];
      assign cand_we[k]   = bus.thr_req_we[T];
      assign cand_addr[k] = bus.thr_req_addr[T*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
      assign cand_data[k] = bus.thr_req_data[T*DATA_WIDTH +: DATA_WIDTH];
      assign bus.thr_req_rdy[T] = any_val && (gnt_local == LW'(k)) &&
                                  bus.mem_req_rdy[c] && !full;
    end

    // First valid candidate at or after rr_ptr, wrapping within the channel.
    always_comb begin
      any_val   = 1'b0;
      gnt_local = '0;
      idx       = '0;
      for (int off = 0; off < TPC; off++) begin
        idx = LW'((int'(rr_ptr_q) + off) % TPC);
        if (!any_val && cand_val[idx]) begin
          any_val   = 1'b1;
          gnt_local = idx;
        end
      end
    end

    // A full FIFO blocks even when a pop lands in the same cycle.
    assign full       = (count_q == CW'(DEPTH));
    assign fire       = any_val && !full && bus.mem_req_rdy[c];
    assign gnt_thread = TW'(c + int'(gnt_local) * NUM_CHANNELS);
    assign pop[c]     = bus.mem_resp_val[c] && (count_q != '0);
    assign head_tag[c] = tag_q[head_q];

    assign bus.mem_req_val[c] = any_val && !full;
    assign bus.mem_req_we[c]  = any_val && cand_we[gnt_local];
    assign bus.mem_req_addr[c*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH] =
      any_val ? cand_addr[gnt_local] : '0;
    assign bus.mem_req_data[c*DATA_WIDTH +: DATA_WIDTH] =
      any_val ? cand_data[gnt_local] : '0;

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
      if (fire) rr_ptr_d = LW'((int'(gnt_local) + 1) % TPC);
      if (fire && !pop[c])      count_d = count_q + 1'b1;
      else if (!fire && pop[c]) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rr_ptr_q <= '0;
        count_q  <= '0;
        head_q   <= '0;
        tail_q   <= '0;
        for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
        count_q  <= count_d;
        if (fire) begin
          tag_q[tail_q] <= gnt_thread;
          tail_q        <= tail_q + 1'b1;
        end
        if (pop[c]) head_q <= head_q + 1'b1;
      end
    end

`ifdef CU_MEM_ARBITER_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else if (any_val && !fire && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
    assign perf_stall_cnt[c*16 +: 16] = stall_q;
`endif
  end

  // Each thread belongs to exactly one channel, so only that channel's pop can target it.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    localparam int CH = t % NUM_CHANNELS;
    logic                  hit;
    logic                  resp_val_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    assign hit = pop[CH] && (head_tag[CH] == TW'(t));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        resp_val_q  <= 1'b0;
        resp_data_q <= '0;
      end else begin
        resp_val_q <= hit;
        if (hit) resp_data_q <= bus.mem_resp_data[CH*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign bus.thr_resp_val[t]                          = resp_val_q;
    assign bus.thr_resp_data[t*DATA_WIDTH +: DATA_WIDTH] = resp_data_q;
  end

endmodule
